// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the SimpleDualPortRAM-backed FWFT FIFO.
package fifo_pkg;

  localparam int FIFO_OUT_BUF_DEPTH = 2;

  // One extra bit beyond the RAM address so full and empty can be told apart.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int fifo_level_width(input int depth);
    return $clog2(depth + FIFO_OUT_BUF_DEPTH) + 1;
  endfunction

endpackage

// File: rtl/SimpleDualPortRAM.sv
// Behavioural simple dual-port RAM: write port A, registered read port B.
// Only the "common_clock" mode is modelled; port B output resets via rstb_i.
module SimpleDualPortRAM #(
  parameter string CLOCKING_MODE    = "common_clock",
  parameter int    DATA_WIDTH       = 32,
  parameter int    BYTE_WRITE_WIDTH = 32,
  parameter int    DATA_DEPTH       = 256,
  parameter int    ADDR_WIDTH       = $clog2(DATA_DEPTH),
  localparam int   WE_WIDTH         = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
  input  logic                  clk_a_i,
  input  logic                  en_a_i,
  input  logic [WE_WIDTH-1:0]   we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic                  clk_b_i,
  input  logic                  en_b_i,
  input  logic                  rstb_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic [DATA_WIDTH-1:0] data_b_o
);

  if (CLOCKING_MODE != "common_clock") begin : g_bad_mode
    $error("SimpleDualPortRAM model supports only common_clock mode");
  end

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] data_b_q;

  always_ff @(posedge clk_a_i) begin
    if (en_a_i) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (we_a_i[i]) begin
          mem_q[addr_a_i][i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
            data_a_i[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_b_i) begin
    if (rstb_i) begin
      data_b_q <= '0;
    end else if (en_b_i) begin
      data_b_q <= mem_q[addr_b_i];
    end
  end

  assign data_b_o = data_b_q;

endmodule

// File: rtl/fifo_out_buf.sv
// Two-entry registered head/skid buffer that absorbs the RAM read latency.
module fifo_out_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  cap_valid_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [1:0]            count_q, count_d;

  // pop_i only arrives while count_q != 0; capture never arrives when full.
  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    case ({cap_valid_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) head_d = cap_data_i;
        else                 skid_d = cap_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = skid_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = cap_data_i;
        end else begin
          head_d = skid_q;
          skid_d = cap_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

  assign valid_o     = (count_q != 2'd0);
  assign head_data_o = head_q;
  assign count_o     = count_q;

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// FWFT FIFO controller around a SimpleDualPortRAM with a 2-entry output buffer.
// Optional synchronous flush input enabled by defining SDPRAM_FIFO_FLUSH_EN.
module sdpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  DATA_DEPTH  = 256,
  localparam int ADDR_WIDTH  = $clog2(DATA_DEPTH),
  localparam int PTR_WIDTH   = fifo_ptr_width(DATA_DEPTH),
  localparam int LEVEL_WIDTH = fifo_level_width(DATA_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DATA_WIDTH-1:0]  s_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
`ifdef SDPRAM_FIFO_FLUSH_EN
  input  logic                   flush_i,
`endif
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   empty_o
);

  if (DATA_DEPTH < 4 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sdpram_fifo_ctrl: DATA_DEPTH must be a power of two and >= 4");
  end

  logic                   flush;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic                   inflight_q, inflight_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   ram_empty, ram_full;
  logic                   push, pop, issue;
  logic [1:0]             buf_count;
  logic [2:0]             buf_occ;
  logic [DATA_WIDTH-1:0]  ram_rd_data;
  logic [0:0]             ram_we;

`ifdef SDPRAM_FIFO_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign push    = s_valid_i && !ram_full && !flush;
  assign pop     = m_valid_o && m_ready_i;
  // Slots the buffer will still owe after this cycle, counting the read in flight.
  assign buf_occ = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
  assign issue   = !ram_empty && (buf_occ < 3'd2) && !flush;
  assign ram_we  = push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + PTR_WIDTH'(issue);
    inflight_d = issue;
    level_d    = level_q + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
    end
  end

  SimpleDualPortRAM #(
    .CLOCKING_MODE    ("common_clock"),
    .DATA_WIDTH       (DATA_WIDTH),
    .BYTE_WRITE_WIDTH (DATA_WIDTH),
    .DATA_DEPTH       (DATA_DEPTH),
    .ADDR_WIDTH       (ADDR_WIDTH)
  ) u_ram (
    .clk_a_i  (clk),
    .en_a_i   (push),
    .we_a_i   (ram_we),
    .addr_a_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .data_a_i (s_data_i),
    .clk_b_i  (clk),
    .en_b_i   (issue),
    .rstb_i   (rst),
    .addr_b_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .data_b_o (ram_rd_data)
  );

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .cap_valid_i (inflight_q),
    .cap_data_i  (ram_rd_data),
    .pop_i       (pop),
    .valid_o     (m_valid_o),
    .head_data_o (m_data_o),
    .count_o     (buf_count)
  );

  assign s_ready_o = !ram_full;
  assign level_o   = level_q;
  assign empty_o   = (level_q == '0);

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Directed scoreboard bench for sdpram_fifo_ctrl (DATA_DEPTH=4, DATA_WIDTH=8).
module tb_sdpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] s_data_i = 8'h00;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [7:0] m_data_o;
  logic [3:0] level_o;
  logic       empty_o;
`ifdef SDPRAM_FIFO_FLUSH_EN
  logic       flush_i = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         model_level = 0;
  logic       last_acc = 1'b0;
  logic       last_pop = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  int         acc_count;
  int         sent;

  always #5 clk = ~clk;

  sdpram_fifo_ctrl #(
    .DATA_WIDTH (8),
    .DATA_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
`ifdef SDPRAM_FIFO_FLUSH_EN
    .flush_i   (flush_i),
`endif
    .level_o   (level_o),
    .empty_o   (empty_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive, decide handshakes at negedge, check level after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    logic clearing;
    logic [7:0] exp_data;
    s_valid_i = v;
    s_data_i  = d;
    m_ready_i = r;
`ifdef SDPRAM_FIFO_FLUSH_EN
    clearing = rst || flush_i;
`else
    clearing = rst;
`endif
    @(negedge clk);
    last_acc = s_valid_i && s_ready_o && !clearing;
    last_pop = m_valid_o && m_ready_i && !clearing;
    if (stall_prev && !clearing) begin
      checkOutput("stall_valid", 32'(m_valid_o), 32'd1);
      checkOutput("stall_data", 32'(m_data_o), 32'(stall_data));
    end
    if (last_pop) begin
      checkOutput("sb_underflow", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_data = sb.pop_front();
        checkOutput("order", 32'(m_data_o), 32'(exp_data));
      end
    end
    if (last_acc) sb.push_back(d);
    if (!clearing) model_level = model_level + int'(last_acc) - int'(last_pop);
    stall_prev = m_valid_o && !m_ready_i && !clearing;
    stall_data = m_data_o;
    @(posedge clk);
    #1;
    if (clearing) begin
      model_level = 0;
      sb.delete();
      stall_prev = 1'b0;
    end
    checkOutput("level", 32'(level_o), 32'(model_level));
    checkOutput("empty", 32'(empty_o), 32'(model_level == 0));
  endtask

  task automatic drainAll();
    for (int c = 0; c < 40 && sb.size() > 0; c++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain_done", 32'(sb.size()), 32'd0);
    checkOutput("drain_valid", 32'(m_valid_o), 32'd0);
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("idle_ready", 32'(s_ready_o), 32'd1);
      checkOutput("idle_valid", 32'(m_valid_o), 32'd0);
    end
    checkOutput("idle_data", 32'(m_data_o), 32'd0);

    // Single word: visible two edges after the push edge
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("lat_k_valid", 32'(m_valid_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lat_k1_valid", 32'(m_valid_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lat_k2_valid", 32'(m_valid_o), 32'd1);
    checkOutput("lat_k2_data", 32'(m_data_o), 32'hA5);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("single_level", 32'(level_o), 32'd1);
    drainAll();

    // Fill: only 6 of 8 back-to-back pushes fit
    acc_count = 0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("fill_acc", 32'(last_acc), 32'(i <= 6));
      if (last_acc) acc_count++;
    end
    checkOutput("fill_count", 32'(acc_count), 32'd6);
    checkOutput("fill_ready", 32'(s_ready_o), 32'd0);
    checkOutput("fill_level", 32'(level_o), 32'd6);
    drainAll();

    // Streaming with m_ready_i=1: one pop per cycle after priming
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 8'(8'h10 + c), 1'b1);
      checkOutput("stream_acc", 32'(last_acc), 32'd1);
      checkOutput("stream_pop", 32'(last_pop), 32'(c >= 3));
      checkOutput("stream_level_max", 32'(level_o <= 4'd3), 32'd1);
    end
    drainAll();

    // Random back-pressure while streaming 50 words
    sent = 0;
    for (int c = 0; c < 400 && sent < 50; c++) begin
      applyStimulus(1'b1, 8'(8'h40 + sent), 1'($urandom_range(0, 1)));
      if (last_acc) sent++;
    end
    checkOutput("rand_sent", 32'(sent), 32'd50);
    drainAll();

    // Reset mid-operation with 5 words held; concurrent push is lost
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
    checkOutput("pre_rst_level", 32'(level_o), 32'd5);
    rst = 1'b1;
    applyStimulus(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    checkOutput("rst_level", 32'(level_o), 32'd0);
    checkOutput("rst_valid", 32'(m_valid_o), 32'd0);
    checkOutput("rst_ready", 32'(s_ready_o), 32'd1);
    repeat (3) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("post_rst_valid", 32'(m_valid_o), 32'd0);
    end
    applyStimulus(1'b1, 8'h5A, 1'b0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("post_rst_data", 32'(m_data_o), 32'h5A);
    drainAll();

`ifdef SDPRAM_FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    checkOutput("pre_flush_level", 32'(level_o), 32'd5);
    flush_i = 1'b1;
    applyStimulus(1'b1, 8'hDD, 1'b1);
    flush_i = 1'b0;
    checkOutput("flush_level", 32'(level_o), 32'd0);
    checkOutput("flush_valid", 32'(m_valid_o), 32'd0);
    repeat (3) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("post_flush_valid", 32'(m_valid_o), 32'd0);
    end
    applyStimulus(1'b1, 8'h3C, 1'b0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("post_flush_data", 32'(m_data_o), 32'h3C);
    drainAll();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: bench did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sdpram_fifo_ctrl.md
Name: sdpram_fifo_ctrl

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO built around one SimpleDualPortRAM instance in "common_clock" mode.
- Sits directly upstream of the RAM: drives its write port A and read port B, and absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer.
- Exposes valid/ready streams on both sides; used for command and data queues in the memory subsystem.

Parameters:
- DATA_WIDTH, 32, payload width in bits; passed to the RAM's DATA_WIDTH and BYTE_WRITE_WIDTH (word-wide writes only).
- DATA_DEPTH, 256, RAM entries; must be a power of two and ≥ 4. Elaboration fails otherwise.
- ADDR_WIDTH (localparam), $clog2(DATA_DEPTH).
- LEVEL_WIDTH (localparam), $clog2(DATA_DEPTH+2)+1.

Ports:
- clk  input  1  single clock; drives both RAM ports.
- rst  input  1  synchronous reset, active-high.
- s_valid_i  input  1  write-side data valid.
- s_ready_o  output  1  write-side ready; equals !ram_full.
- s_data_i  input  DATA_WIDTH  write payload.
- m_valid_o  output  1  read-side data valid; head of FIFO is present.
- m_ready_i  input  1  read-side consumer ready.
- m_data_o  output  DATA_WIDTH  head-of-FIFO payload; stable while m_valid_o && !m_ready_i.
- level_o  output  LEVEL_WIDTH  total entries held: RAM + in-flight read + output buffer.
- empty_o  output  1  level_o == 0.

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, output buffer empty, in-flight flag 0. Outputs: s_ready_o=1, m_valid_o=0, m_data_o=0, level_o=0, empty_o=1.
- Reset mid-operation discards all contents; the RAM array itself is not cleared.
- Pointers are ADDR_WIDTH+1 bits. The MSB is the wrap bit.
  - ram_empty: wr_ptr == rd_ptr.
  - ram_full: low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DATA_DEPTH.
- Push = s_valid_i && s_ready_o.
  - Same cycle: en_a_i=1, we_a_i=all ones, addr_a_i=wr_ptr[ADDR_WIDTH-1:0], data_a_i=s_data_i.
  - wr_ptr increments at the edge.
- Read issue = !ram_empty && (buf_count + inflight − pop) < 2.
  - en_b_i=1, addr_b_i=rd_ptr[ADDR_WIDTH-1:0]; rd_ptr increments.
  - inflight is set for the next cycle.
  - RAM rstb input is tied to rst.
- Data capture: when inflight=1, data_b_o is written into the output buffer at the edge ending that cycle.
  - The output buffer is 2 entries (head + skid).
  - Pop = m_valid_o && m_ready_i, which advances the head.
  - Capture and pop in the same cycle are legal; buffer occupancy is unchanged.
- m_valid_o = buffer non-empty. m_data_o = buffer head, registered. No combinational path from s_* to m_*.
- Latency: a word pushed at edge k is on m_valid_o/m_data_o after edge k+2, when the FIFO was empty and m_ready_i is irrelevant.
- Throughput: 1 word/cycle sustained in both directions once primed.
- Push while ram_full: s_ready_o=0, nothing written.
- Pop is never possible while m_valid_o=0; m_ready_i is ignored in that case.
- Simultaneous push and read issue on the same RAM address cannot occur. The read address is always behind the write address, so RAM WRITE_MODE does not matter.
- level_o: +1 on push, −1 on pop, unchanged on both. Maximum value is DATA_DEPTH+2.

Optional Feature:
- Macro: SDPRAM_FIFO_FLUSH_EN.
- When defined:
  - Adds input flush_i (1 bit).
  - flush_i=1 has the same effect as rst on pointers, buffer, inflight and level at that edge.
  - A push in the flush cycle is dropped.
  - A RAM read in flight is discarded.
  - Priority: rst > flush_i > push/pop.
- When undefined: the port is absent and the logic is identical to flush_i tied to 0.

Decomposition:
- Shared package fifo_pkg holds:
  - a ptr_t-style width function fifo_ptr_width(depth);
  - the LEVEL_WIDTH calculation;
  - the constant FIFO_OUT_BUF_DEPTH=2.
- One sub-module, fifo_out_buf: the 2-entry registered valid/ready buffer with capture, pop and count outputs.
- The top level holds the pointers, issue logic and the SimpleDualPortRAM instance.

Test Plan (DATA_DEPTH=4, DATA_WIDTH=8):
- Reset then idle → s_ready_o=1, m_valid_o=0, level_o=0, empty_o=1 for 10 cycles.
- Single push 0xA5 at edge k, m_ready_i=0 → m_valid_o=1, m_data_o=0xA5 after edge k+2. Holds stable; level_o=1.
- Push 8 words 0x01..0x08 back-to-back, m_ready_i=0 → 6 accepted (4 RAM + 2 buffer). s_ready_o=0 after the 6th accept; level_o=6. Draining yields 0x01..0x06 in order.
- Continuous push and pop with m_ready_i=1, 20 words → output order preserved, one word per cycle after 2-cycle priming, level_o ≤ 3, pointers wrap over 2*4 boundary.
- m_ready_i toggled pseudo-randomly while streaming 50 words → no loss or duplication. m_data_o stable while stalled.
- Assert rst with level_o=5 → next cycle level_o=0, m_valid_o=0. With SDPRAM_FIFO_FLUSH_EN, flush_i gives the same result and a concurrent push is dropped.
